dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: CPU MEM stage
  - port 1: debug/loader port, which writes programs and data and reads results.
- Sequences each access through a fixed-latency memory using a small FSM.
- Grants round-robin, with a debug lock that keeps the CPU off the memory during loading.
- Sits between the EX/MEM pipeline register outputs and the data memory.

Parameters:
- AW, 10, word address width driven to memory.
- DW, 32, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- dbg_lock  in  1  when 1, port 0 is never granted.
- p0_req_valid  in  1  CPU access request.
- p0_req_write  in  1  1=store, 0=load.
- p0_req_addr  in  AW  word address.
- p0_req_wdata  in  DW  store data.
- p0_req_ready  out  1  request accepted this cycle (combinational).
- p0_rsp_valid  out  1  one-cycle completion pulse.
- p0_rsp_rdata  out  DW  load data (0 for stores).
- p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_req_ready, p1_rsp_valid, p1_rsp_rdata  same as port 0, for the debug port.
- p0_busy  out  1  high while p0_req_valid is outstanding (not yet answered); drives CPU stall.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (rst=0, async), all outputs and registers clear:
  - state=IDLE, owner=0, last_grant=1 (so port 0 wins the first tie), counter=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0 and rsp_rdata=0 on both ports.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Eligible ports: p1 if p1_req_valid; p0 if p0_req_valid & ~dbg_lock.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On grant: pk_req_ready=1 combinationally; latch write/addr/wdata/owner; update last_grant; next state ISSUE.
  - No eligible port: stay in IDLE with all ready=0.
- Requester rules:
  - Must hold req fields stable while valid and ready=0.
  - May drop valid only after ready.
- ISSUE: mem_en=1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the latch; counter=MEM_LAT; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1: capture mem_rdata (for a load) into the owner's rsp_rdata, or 0 for a store; next state RESP.
- RESP:
  - Owner's rsp_valid=1 for one cycle.
  - Arbitration for the next request occurs in this same cycle: a grant here moves to ISSUE, no grant moves to IDLE.
- Latency: a request accepted in cycle T has mem_en at T+1 and rsp_valid at T+2+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles.
- mem_en is 0 in every state except ISSUE. mem_addr/mem_wdata hold their last values.
- p0_busy = p0_req_valid & ~p0_rsp_valid, and includes cycles lost to dbg_lock.
- dbg_lock asserted while a port-0 access is in ISSUE/WAIT/RESP: that access completes normally; the lock takes effect at the next arbitration point.
- Reset asserted mid-access: the access is abandoned with no response. mem_en drops immediately, which may leave a partial memory read with no effect.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - State encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Port index constants PORT_CPU=0, PORT_DBG=1.
- Sub-module rr_arb2:
  - Purely combinational 2-way round-robin pick.
  - Inputs: eligible vector, last_grant. Outputs: one-hot grant.
  - Shared by the IDLE and RESP arbitration.

Test Plan:
- p0 single load, addr=0x004, MEM_LAT=1, memory preloaded 0xDEADBEEF:
  - accepted at T, mem_en at T+1, p0_rsp_valid at T+3 with rdata=0xDEADBEEF.
  - p0_busy high T..T+2.
- p1 store, addr=0x010, wdata=0x12345678, then p1 load of the same address:
  - mem_we=1 on the first ISSUE.
  - store rsp_rdata=0.
  - load returns 0x12345678.
  - second ready in the RESP cycle of the first access.
- p0 and p1 valid simultaneously after reset, held for 4 accesses:
  - grant order p0, p1, p0, p1.
  - each rsp_valid goes to the correct port.
- dbg_lock=1 with both valid: only p1 is granted across 3 accesses; p0_busy stays 1.
  - Clear the lock: p0 is granted at the next arbitration point.
- MEM_LAT=3, p0 load: rsp_valid exactly 5 cycles after accept; mem_en high exactly 1 cycle.
- Drive rst=0 during WAIT, release 2 cycles later:
  - no rsp_valid on either port.
  - mem_en=0 while in reset.
  - state IDLE.
  - the next p0 request is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the latency counter width.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Holds MEM_LAT values up to 15
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone eligible port wins, a tie goes to the port
// that did not win last time.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (eligible[PORT_CPU] && eligible[PORT_DBG]) begin
         grant[~last_grant] = 1'b1;
      end else begin
         grant = eligible;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and
// the debug/loader port (port 1), one fixed-latency access at a time.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dbg_lock,
   input  logic          p0_req_valid,
   input  logic          p0_req_write,
   input  logic [AW-1:0] p0_req_addr,
   input  logic [DW-1:0] p0_req_wdata,
   output logic          p0_req_ready,
   output logic          p0_rsp_valid,
   output logic [DW-1:0] p0_rsp_rdata,
   input  logic          p1_req_valid,
   input  logic          p1_req_write,
   input  logic [AW-1:0] p1_req_addr,
   input  logic [DW-1:0] p1_req_wdata,
   output logic          p1_req_ready,
   output logic          p1_rsp_valid,
   output logic [DW-1:0] p1_rsp_rdata,
   output logic          p0_busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t       state;
   logic             owner;
   logic             last_grant;
   logic [CNT_W-1:0] cnt;

   logic [1:0] eligible;
   logic [1:0] grant;
   logic       arb_point;
   logic       granted;
   logic       gnt_port;

   // The debug lock only masks eligibility; an access already in flight finishes
   assign eligible = {p1_req_valid, p0_req_valid & ~dbg_lock};

   rr_arb2 u_rr_arb2 (
      .eligible   (eligible),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign arb_point    = (state == ST_IDLE) || (state == ST_RESP);
   assign granted      = arb_point && (grant != 2'b00);
   assign gnt_port     = grant[PORT_DBG];
   assign p0_req_ready = arb_point & grant[PORT_CPU];
   assign p1_req_ready = arb_point & grant[PORT_DBG];
   assign p0_busy      = p0_req_valid & ~p0_rsp_valid;

   // mem_we/mem_addr/mem_wdata double as the request latch for the access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         owner        <= PORT_CPU;
         last_grant   <= PORT_DBG;
         cnt          <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         p0_rsp_valid <= 1'b0;
         p0_rsp_rdata <= '0;
         p1_rsp_valid <= 1'b0;
         p1_rsp_rdata <= '0;
      end else begin
         mem_en       <= 1'b0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (granted) begin
                  owner      <= gnt_port;
                  last_grant <= gnt_port;
                  mem_en     <= 1'b1;
                  mem_we     <= gnt_port ? p1_req_write : p0_req_write;
                  mem_addr   <= gnt_port ? p1_req_addr  : p0_req_addr;
                  mem_wdata  <= gnt_port ? p1_req_wdata : p0_req_wdata;
                  state      <= ST_ISSUE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               cnt   <= CNT_W'(MEM_LAT);
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= ST_RESP;
                  if (owner == PORT_DBG) begin
                     p1_rsp_valid <= 1'b1;
                     p1_rsp_rdata <= mem_we ? {DW{1'b0}} : mem_rdata;
                  end else begin
                     p0_rsp_valid <= 1'b1;
                     p0_rsp_rdata <= mem_we ? {DW{1'b0}} : mem_rdata;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
